// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: run-time ratio config channel for clk_div_multi.
// master raises a request, slave accepts it with cfg_ready.
interface clk_div_multi_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_high;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel divider with per-period tick strobe.
// Define CLK_DIV_MULTI_DUTY_EN for programmable high time (cfg_high).
module clk_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    clk_div_multi_if.slave      cfg,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] tick
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

    // ceil(n/2) without the n+1 overflow at the top of the range
    function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] n);
        return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
    endfunction

    logic [CHANNELS-1:0] pend_vec;
    logic                cfg_fire;
    logic [DIV_W-1:0]    wr_n;
`ifdef CLK_DIV_MULTI_DUTY_EN
    logic [DIV_W-1:0]    wr_h;
`else
    logic                unused_high;
    assign unused_high = ^cfg.cfg_high;
`endif

    // accept whenever the addressed channel has no write outstanding
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_ch == CH_W'(i) && pend_vec[i]) begin
                cfg.cfg_ready = 1'b0;
            end
        end
    end

    assign cfg_fire = cfg.cfg_valid & cfg.cfg_ready;

    // clamp the requested ratio (and high time) before it is stored
    always_comb begin
        wr_n = (cfg.cfg_div < TWO) ? TWO : cfg.cfg_div;
`ifdef CLK_DIV_MULTI_DUTY_EN
        if (cfg.cfg_high == '0) begin
            wr_h = ONE;
        end else if (cfg.cfg_high >= wr_n) begin
            wr_h = wr_n - ONE;
        end else begin
            wr_h = cfg.cfg_high;
        end
`endif
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_W-1:0] phase;
        logic [DIV_W-1:0] n_act;
        logic [DIV_W-1:0] n_pend;
        logic [DIV_W-1:0] n_nxt;
        logic [DIV_W-1:0] h_nxt;
        logic [DIV_W-1:0] ph_nxt;
        logic             run;
        logic             pend;
        logic             wr;
        logic             wrap;
        logic             apply;
        logic             restart;
        logic             div_q;
        logic             tick_q;
`ifdef CLK_DIV_MULTI_DUTY_EN
        logic [DIV_W-1:0] h_act;
        logic [DIV_W-1:0] h_pend;
`endif

        assign wr    = cfg_fire && (cfg.cfg_ch == CH_W'(g));
        // wrap only counts once the channel has actually started
        assign wrap  = run && (phase == n_act - ONE);
        assign apply = pend && (!en[g] || sync || wrap);
        assign n_nxt = apply ? n_pend : n_act;
`ifdef CLK_DIV_MULTI_DUTY_EN
        assign h_nxt = apply ? h_pend : h_act;
`else
        assign h_nxt = half_up(n_nxt);
`endif
        assign restart = !run || sync || wrap;
        assign ph_nxt  = restart ? '0 : phase + ONE;

        // phase counter and registered outputs; the new period uses n_nxt/h_nxt
        always_ff @(posedge clk) begin
            if (rst) begin
                run    <= 1'b0;
                phase  <= '0;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!en[g]) begin
                run    <= 1'b0;
                phase  <= '0;
                div_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                run    <= 1'b1;
                phase  <= ph_nxt;
                div_q  <= (ph_nxt < h_nxt);
                tick_q <= (ph_nxt == '0);
            end
        end

        // pending/active ratio; apply and write never coincide since ready=!pend
        always_ff @(posedge clk) begin
            if (rst) begin
                n_act  <= DEF_N;
                n_pend <= DEF_N;
                pend   <= 1'b0;
`ifdef CLK_DIV_MULTI_DUTY_EN
                h_act  <= half_up(DEF_N);
                h_pend <= half_up(DEF_N);
`endif
            end else if (apply) begin
                n_act  <= n_pend;
                pend   <= 1'b0;
`ifdef CLK_DIV_MULTI_DUTY_EN
                h_act  <= h_pend;
`endif
            end else if (wr) begin
                n_pend <= wr_n;
                pend   <= 1'b1;
`ifdef CLK_DIV_MULTI_DUTY_EN
                h_pend <= wr_h;
`endif
            end
        end

        assign pend_vec[g] = pend;
        assign div_clk[g]  = div_q;
        assign tick[g]     = tick_q;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi.
// Expected tick/div_clk/cfg_ready are queued per edge and popped after it.
module tb_clk_div_multi;
    localparam int CHANNELS = 4;
    localparam int DIV_W    = 16;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] d;
        logic       r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = 4'b0;
    logic       sync = 1'b0;
    logic [3:0] div_clk;
    logic [3:0] tick;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    clk_div_multi_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) bus ();

    clk_div_multi #(
        .CHANNELS(CHANNELS),
        .DIV_W(DIV_W),
        .DEFAULT_DIV(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync(sync),
        .cfg(bus),
        .div_clk(div_clk),
        .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {tick, div_clk} of one channel sitting at phase ph with high time h
    function automatic logic [1:0] wave(input int ph, input int h);
        return {(ph == 0), (ph < h)};
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        en = 4'b0;
        sync = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch = 2'd0;
        bus.cfg_div = '0;
        bus.cfg_high = '0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{t: 4'b0, d: 4'b0, r: 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL reset[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         k, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_default();
        exp_t e;
        logic [1:0] w;
        en = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            w = wave(k % 16, 8);
            sb.push_back('{t: {3'b0, w[1]}, d: {3'b0, w[0]}, r: 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL default[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         k, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
    endtask

    task automatic test_cfg_latency();
        exp_t e;
        logic [1:0] w;
        en = 4'b0000;
        bus.cfg_ch = 2'd0;
        sb.push_back('{t: 4'b0, d: 4'b0, r: 1'b1});
        step();
        e = sb.pop_front();
        checks++;
        if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
            errors++;
            $display("FAIL latency_off: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                     tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
        end
        en = 4'b0001;
        for (int j = 0; j < 31; j++) begin
            if (j == 4) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_div = 16'd5;
            end
            if (j < 16) w = wave(j, 8);
            else w = wave((j - 16) % 5, 3);
            sb.push_back('{t: {3'b0, w[1]}, d: {3'b0, w[0]}, r: (j < 4 || j >= 16)});
            step();
            bus.cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL latency[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         j, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
            if (j == 8) begin
                bus.cfg_ch = 2'd1;
                #1;
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_ready_ch1: rdy=%b, expected 1", bus.cfg_ready);
                end
                bus.cfg_ch = 2'd0;
                #1;
            end
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        logic [1:0] w;
        bus.cfg_ch = 2'd0;
        for (int v = 0; v < 2; v++) begin
            en = 4'b0000;
            for (int k = 0; k < 8; k++) begin
                if (k == 0) begin
                    bus.cfg_valid = 1'b1;
                    bus.cfg_div = DIV_W'(v);
                end
                if (k == 2) en = 4'b0001;
                if (k < 2) w = 2'b00;
                else w = wave((k - 2) % 2, 1);
                sb.push_back('{t: {3'b0, w[1]}, d: {3'b0, w[0]}, r: (k != 0)});
                step();
                bus.cfg_valid = 1'b0;
                e = sb.pop_front();
                checks++;
                if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                    errors++;
                    $display("FAIL clamp%0d[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                             v, k, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
                end
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        logic [1:0] w0;
        logic [1:0] w1;
        int p0;
        int p1;
        en = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            bus.cfg_valid = (k < 2);
            bus.cfg_ch = (k == 0) ? 2'd0 : 2'd1;
            bus.cfg_div = (k == 0) ? 16'd16 : 16'd6;
            sb.push_back('{t: 4'b0, d: 4'b0, r: (k == 2)});
            step();
            bus.cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL sync_cfg[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         k, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
        for (int i = 0; i < 57; i++) begin
            en = (i < 5) ? 4'b0001 : 4'b0011;
            sync = (i == 8);
            if (i < 8) begin
                p0 = i;
                p1 = i - 5;
            end else begin
                p0 = (i - 8) % 16;
                p1 = (i - 8) % 6;
            end
            w0 = wave(p0, 8);
            w1 = (i < 5) ? 2'b00 : wave(p1, 3);
            sb.push_back('{t: {2'b0, w1[1], w0[1]}, d: {2'b0, w1[0], w0[0]}, r: 1'b1});
            step();
            sync = 1'b0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL sync[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         i, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
    endtask

    task automatic test_disable();
        exp_t e;
        logic [1:0] w;
        for (int i = 0; i < 8; i++) begin
            en = (i == 4) ? 4'b0000 : 4'b0100;
            if (i < 4) w = wave(i, 8);
            else if (i == 4) w = 2'b00;
            else w = wave(i - 5, 8);
            sb.push_back('{t: {1'b0, w[1], 2'b0}, d: {1'b0, w[0], 2'b0}, r: 1'b1});
            step();
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL disable[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         i, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
    endtask

    task automatic test_rst_pending();
        exp_t e;
        logic [1:0] w;
        bus.cfg_ch = 2'd2;
        en = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            bus.cfg_valid = (i == 0);
            bus.cfg_div = 16'd5;
            rst = (i == 1);
            if (i == 0) w = wave(3, 8);
            else if (i == 1) w = 2'b00;
            else w = wave((i - 2) % 16, 8);
            sb.push_back('{t: {1'b0, w[1], 2'b0}, d: {1'b0, w[0], 2'b0}, r: (i != 0)});
            step();
            bus.cfg_valid = 1'b0;
            rst = 1'b0;
            e = sb.pop_front();
            checks++;
            if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                errors++;
                $display("FAIL rst_pending[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                         i, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
            end
        end
    endtask

    task automatic test_duty();
        exp_t e;
        logic [1:0] w;
        int h_in[3] = '{3, 0, 12};
        int h_exp[3];
`ifdef CLK_DIV_MULTI_DUTY_EN
        h_exp = '{3, 1, 9};
`else
        h_exp = '{5, 5, 5};
`endif
        bus.cfg_ch = 2'd3;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 22; k++) begin
                en = (k < 2) ? 4'b0000 : 4'b1000;
                bus.cfg_valid = (k == 0);
                bus.cfg_div = 16'd10;
                bus.cfg_high = DIV_W'(h_in[c]);
                w = (k < 2) ? 2'b00 : wave((k - 2) % 10, h_exp[c]);
                sb.push_back('{t: {w[1], 3'b0}, d: {w[0], 3'b0}, r: (k != 0)});
                step();
                bus.cfg_valid = 1'b0;
                e = sb.pop_front();
                checks++;
                if (tick !== e.t || div_clk !== e.d || bus.cfg_ready !== e.r) begin
                    errors++;
                    $display("FAIL duty%0d[%0d]: tick=%b div=%b rdy=%b, expected tick=%b div=%b rdy=%b",
                             h_in[c], k, tick, div_clk, bus.cfg_ready, e.t, e.d, e.r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_cfg_latency();
        test_clamp();
        test_sync();
        test_disable();
        test_rst_pending();
        test_duty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
